serial_add_ctrl: RTL and testbench
==================================

// Module: serial_add_ctrl
// PURPOSE
//  Bit-serial adder controller: time-multiplexes one full-adder datapath, built from two
//  ha instances plus an OR, over a WIDTH-bit add, LSB first, one bit per clock.
//  Sits between a requesting unit (start/done handshake) and the shared ha datapath.
//  Trades WIDTH cycles of latency for a single 1-bit adder.
// PARAMETERS
//  WIDTH    8    operand/result width in bits; legal range WIDTH >= 2
// PORTS
//  clk        in   1      single clock; all state updates on rising edge
//  rst        in   1      asynchronous, active-high reset
//  start      in   1      request; sampled only in IDLE
//  a          in   WIDTH  operand A; captured on accepted start
//  b          in   WIDTH  operand B; captured on accepted start
//  busy       out  1      1 while in SHIFT
//  done       out  1      1-cycle pulse; result valid
//  sum        out  WIDTH  result; held stable from done until the next accepted start
//  carry_out  out  1      final carry; held the same as sum
// BEHAVIOUR
//  - Reset: async, active-high. State=IDLE; busy, done, sum, carry_out and the bit counter
//    all clear to 0. The operand shift regs and the internal carry also clear.
//  - FSM states: IDLE, SHIFT, DONE.
//    IDLE  -> SHIFT on start=1. Capture a, b into shift regs, carry<=0, cnt<=0.
//    SHIFT -> each edge:
//             {c,s} = full_add(A[0], B[0], carry), built from ha(A0,B0) then ha(s1,carry)
//             c = carry1 | carry2
//             sum <= {s, sum[WIDTH-1:1]}; A, B shift right; carry <= c; cnt <= cnt+1
//             When cnt == WIDTH-1 at the edge: carry_out <= c, go to DONE.
//    DONE  -> IDLE unconditionally after one cycle.
//  - Registered outputs: busy = (state==SHIFT), done = (state==DONE).
//  - Latency: start sampled at edge E0. Bits are computed at edges E1..E_WIDTH.
//    done is high for exactly the cycle following E_WIDTH. The next start can be accepted at
//    E_WIDTH+2 at the earliest.
//  - Arithmetic: result is modulo 2^WIDTH; the overflow bit goes to carry_out.
//    cnt is $clog2(WIDTH) bits wide and never wraps past WIDTH-1.
//  - start while in SHIFT or DONE: ignored. No queuing, and captured operands are unaffected.
//  - a and b may change freely after the capture edge.
//  - sum/carry_out are not valid while busy=1; they hold only after done.
//  - rst asserted mid-operation: immediate abort, all outputs 0, no done pulse.
//    After rst deasserts, start is accepted on the next edge.
//  - X/Z on a or b at capture propagates; no checking in RTL.
// CONFIGURATION
//  SERIAL_ADD_SUB_EN defined:
//   - Extra port: sub in 1. Captured with start.
//   - sub=1: B is inverted at capture and the initial carry is 1, so the result is A-B.
//   - carry_out = 1 means no borrow (A >= B, unsigned).
//   - sub=0: plain addition, identical to the build without the macro.
//  SERIAL_ADD_SUB_EN undefined: no sub port; add-only; logic as described above.
// TESTING (WIDTH=8)
//  1. rst pulse, then idle -> busy=0, done=0, sum=0, carry_out=0.
//  2. a=3, b=5, start for 1 cycle
//     -> busy for 8 cycles; done high exactly 1 cycle, 8 edges after the start edge.
//     -> sum=8, carry_out=0.
//  3. a=255, b=1 -> sum=0, carry_out=1.
//     a=200, b=100 -> sum=44, carry_out=1.
//  4. Start accepted (a=10, b=20); start re-pulsed at bit 3 with a=99, b=99
//     -> ignored; result sum=30, only one done pulse.
//  5. rst asserted at bit 4 of 170+85 -> outputs 0 at once, no done pulse.
//     Then a new 1+1 -> sum=2, carry_out=0.
//  6. [SERIAL_ADD_SUB_EN] sub=1: 5-3 -> sum=2, carry_out=1.
//     3-5 -> sum=254, carry_out=0.
//     sub=0, 5+3 -> sum=8, carry_out=0.

Source files
------------

// File: rtl/serial_add_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : serial_add_ctrl (with helper ha)                                |
// | Brief    : Bit-serial WIDTH-bit adder, LSB first, one bit per clock,       |
// |            built from two half adders. SERIAL_ADD_SUB_EN adds subtract.    |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+

module ha (
  input  logic a,
  input  logic b,
  output logic s,
  output logic c
);
  assign s = a ^ b;
  assign c = a & b;
endmodule

module serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out
`ifdef SERIAL_ADD_SUB_EN
  ,
  input  logic             sub
`endif
);

  localparam int                 c_cnt_w = $clog2(WIDTH);
  localparam logic [c_cnt_w-1:0] c_last  = c_cnt_w'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t             r_state, w_next;
  logic [WIDTH-1:0]   r_a, r_b, r_sum;
  logic [c_cnt_w-1:0] r_cnt;
  logic               r_carry, r_carry_out, r_busy, r_done;
  logic               w_capture, w_shift, w_last;
  logic               w_s1, w_c1, w_s, w_c2, w_c;

  // Shared 1-bit full adder: two half adders plus an OR for the carry.
  ha u_ha0 (.a(r_a[0]), .b(r_b[0]),  .s(w_s1), .c(w_c1));
  ha u_ha1 (.a(w_s1),   .b(r_carry), .s(w_s),  .c(w_c2));
  assign w_c = w_c1 | w_c2;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_next;
      r_busy  <= (w_next == SHIFT);
      r_done  <= (w_next == DONE);
    end
  end

  always_comb begin
    w_next    = r_state;
    w_capture = 1'b0;
    w_shift   = 1'b0;
    w_last    = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_capture = 1'b1;
          w_next    = SHIFT;
        end
      end
      SHIFT: begin
        w_shift = 1'b1;
        if (r_cnt == c_last) begin
          w_last = 1'b1;
          w_next = DONE;
        end
      end
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a         <= '0;
      r_b         <= '0;
      r_sum       <= '0;
      r_cnt       <= '0;
      r_carry     <= 1'b0;
      r_carry_out <= 1'b0;
    end else if (w_capture) begin
      r_a   <= a;
      r_cnt <= '0;
`ifdef SERIAL_ADD_SUB_EN
      // Subtraction as A + ~B + 1: invert B and seed the carry.
      r_b     <= sub ? ~b : b;
      r_carry <= sub;
`else
      r_b     <= b;
      r_carry <= 1'b0;
`endif
    end else if (w_shift) begin
      r_sum   <= {w_s, r_sum[WIDTH-1:1]};
      r_a     <= r_a >> 1;
      r_b     <= r_b >> 1;
      r_carry <= w_c;
      if (w_last) r_carry_out <= w_c;
      else        r_cnt       <= r_cnt + 1'b1;
    end
  end

  assign busy      = r_busy;
  assign done      = r_done;
  assign sum       = r_sum;
  assign carry_out = r_carry_out;

endmodule
`default_nettype wire

// File: tb/tb_serial_add_ctrl.sv
`default_nettype none
// Self-checking bench for serial_add_ctrl (WIDTH=8): vector table plus
// hand-written start-while-busy and mid-operation reset sequences.
module tb_serial_add_ctrl;

  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [WIDTH-1:0] a, b;
  logic             busy, done, carry_out;
  logic [WIDTH-1:0] sum;
`ifdef SERIAL_ADD_SUB_EN
  logic             sub = 1'b0;
`endif

  int n_total = 0;
  int n_pass  = 0;

  typedef struct {
    logic [WIDTH-1:0] va;
    logic [WIDTH-1:0] vb;
    logic             vsub;
    logic [WIDTH-1:0] exp_sum;
    logic             exp_cout;
  } vec_t;

  vec_t vecs[$];

  serial_add_ctrl #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .a         (a),
    .b         (b),
    .busy      (busy),
    .done      (done),
    .sum       (sum),
    .carry_out (carry_out)
`ifdef SERIAL_ADD_SUB_EN
    ,
    .sub       (sub)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Issue one operation and check the busy window, done pulse and result.
  task automatic run_op(input string name, input vec_t v);
    int busy_cycles;
    @(negedge clk);
    a = v.va;
    b = v.vb;
`ifdef SERIAL_ADD_SUB_EN
    sub = v.vsub;
`endif
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    a = '1;
    b = '1;
    busy_cycles = 0;
    for (int i = 0; i < WIDTH; i++) begin
      if (busy && !done) busy_cycles++;
      @(negedge clk);
    end
    check({name, " busy_cycles"}, busy_cycles, WIDTH);
    check({name, " done_high"}, {busy, done}, 2'b01);
    check({name, " sum"}, sum, v.exp_sum);
    check({name, " carry_out"}, carry_out, v.exp_cout);
    @(negedge clk);
    check({name, " done_low"}, {busy, done}, 2'b00);
    check({name, " sum_held"}, {carry_out, sum}, {v.exp_cout, v.exp_sum});
  endtask

  initial begin
    int   dones;
    logic [WIDTH-1:0] sum_at_done;

    rst = 1'b1; start = 1'b0; a = '0; b = '0;
    vecs.push_back('{8'd3,   8'd5,   1'b0, 8'd8,   1'b0});
    vecs.push_back('{8'd255, 8'd1,   1'b0, 8'd0,   1'b1});
    vecs.push_back('{8'd200, 8'd100, 1'b0, 8'd44,  1'b1});
    vecs.push_back('{8'd0,   8'd0,   1'b0, 8'd0,   1'b0});
    vecs.push_back('{8'd170, 8'd85,  1'b0, 8'd255, 1'b0});
    vecs.push_back('{8'd128, 8'd128, 1'b0, 8'd0,   1'b1});
    vecs.push_back('{8'd255, 8'd255, 1'b0, 8'd254, 1'b1});
`ifdef SERIAL_ADD_SUB_EN
    vecs.push_back('{8'd5,   8'd3,   1'b1, 8'd2,   1'b1});
    vecs.push_back('{8'd3,   8'd5,   1'b1, 8'd254, 1'b0});
    vecs.push_back('{8'd7,   8'd7,   1'b1, 8'd0,   1'b1});
    vecs.push_back('{8'd5,   8'd3,   1'b0, 8'd8,   1'b0});
`endif

    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("reset busy", busy, 1'b0);
    check("reset done", done, 1'b0);
    check("reset sum", sum, 8'd0);
    check("reset carry_out", carry_out, 1'b0);

    foreach (vecs[i]) run_op($sformatf("vec%0d", i), vecs[i]);

    // Start re-pulsed mid-operation with different operands must be ignored.
    @(negedge clk);
    a = 8'd10; b = 8'd20; start = 1'b1;
`ifdef SERIAL_ADD_SUB_EN
    sub = 1'b0;
`endif
    @(negedge clk);
    start = 1'b0;
    dones = 0;
    sum_at_done = '0;
    for (int k = 0; k < 14; k++) begin
      if (k == 3) begin a = 8'd99; b = 8'd99; start = 1'b1; end
      if (k == 4) start = 1'b0;
      @(negedge clk);
      if (done) begin dones++; sum_at_done = sum; end
    end
    check("restart done_count", dones, 1);
    check("restart sum", sum_at_done, 8'd30);

    // Reset mid-operation aborts at once and suppresses done.
    @(negedge clk);
    a = 8'd170; b = 8'd85; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("abort outputs", {busy, done, carry_out, sum}, 11'd0);
    @(negedge clk);
    rst = 1'b0;
    dones = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (done || busy) dones++;
    end
    check("abort no_done", dones, 0);
    run_op("after_abort", '{8'd1, 8'd1, 1'b0, 8'd2, 1'b0});

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
`default_nettype wire
